// File: rtl/addsub_wb_stage.sv
// addsub_wb_stage
// Registered write-back stage behind the 16-bit add/sub unit. Results are
// held in a 2-entry skid buffer in front of the register-file write port.
// The stage also keeps the architectural status flags {N,Z,C,V} and a
// sticky overflow bit. Flags are updated when a result is accepted, not
// when it is written back.

module addsub_wb_stage #(
  parameter int WIDTH  = 16,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_carry,
  input  logic              in_over,
  input  logic              in_sign,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags,
  output logic              sticky_ovf,
  input  logic              sticky_clr
);

  // Buffer occupancy
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t state_q;
  occ_t state_d;

  logic              in_ready_q;
  logic              push;
  logic              pop;
  logic              load_head_in;
  logic              load_head_tail;
  logic              load_tail;

  logic [WIDTH-1:0]  head_data;
  logic [DEST_W-1:0] head_dest;
  logic [WIDTH-1:0]  tail_data;
  logic [DEST_W-1:0] tail_dest;

  logic [3:0]        flags_q;
  logic              sticky_q;
  logic              flag_n;
  logic              flag_z;

  // in_ready is a flop, so out_ready never reaches it combinationally.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  assign out_data   = head_data;
  assign out_dest   = head_dest;
  assign flags      = flags_q;
  assign sticky_ovf = sticky_q;

  // N only means "negative" for signed operations.
  assign flag_n = in_sign ? in_y[WIDTH-1] : 1'b0;
  assign flag_z = (in_y == '0);

  // Next occupancy and which storage registers load this cycle
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_tail = 1'b1;
          state_d   = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          load_head_tail = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Occupancy register and the registered ready derived from its next value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Head and tail entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      head_dest <= '0;
      tail_data <= '0;
      tail_dest <= '0;
    end else begin
      if (load_head_in) begin
        head_data <= in_y;
        head_dest <= in_dest;
      end else if (load_head_tail) begin
        head_data <= tail_data;
        head_dest <= tail_dest;
      end
      if (load_tail) begin
        tail_data <= in_y;
        tail_dest <= in_dest;
      end
    end
  end

  // Status flags follow accepted, flag-writing results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (push && in_flag_we) begin
      flags_q <= {flag_n, flag_z, in_carry, in_over};
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (push && in_flag_we && in_over) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

endmodule
